// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// The master is the FSM; the slave is the datapath consuming the enables.
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             IRWrite;
   logic             MemtoReg;
   logic             RegDst;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       PCSource;
   logic             illegal_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
      output IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
      output ALUSrcB, ALUOp, PCSource, illegal_op, state,
      output instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
      input  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
      input  ALUSrcB, ALUOp, PCSource, illegal_op, state,
      input  instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with memory stall,
// illegal-opcode pulse and retired-instruction counter.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic clk,
   input  logic reset,
   multicycle_control_if.master bus
);
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ill_q, ill_d;
   logic             retire;

   logic op_lw, op_sw, op_r, op_beq, op_j, op_addi;

   assign op_lw   = bus.opcode == 6'b100011;
   assign op_sw   = bus.opcode == 6'b101011;
   assign op_r    = bus.opcode == 6'b000000;
   assign op_beq  = bus.opcode == 6'b000100;
   assign op_j    = bus.opcode == 6'b000010;
   assign op_addi = bus.opcode == 6'b001000;

   always_comb begin
      state_d = S_FETCH;
      ill_d   = 1'b0;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:
            state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (1'b1)
               op_lw, op_sw: state_d = S_MEMADR;
               op_r:         state_d = S_EXEC;
               op_beq:       state_d = S_BRANCH;
               op_j:         state_d = S_JUMP;
               op_addi:      state_d = S_ADDIEX;
               default: begin
                  state_d = S_FETCH;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_MEMADR:
            state_d = op_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:
            state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:
            retire = 1'b1;
         S_MEMWR: begin
            state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            retire  = bus.mem_ready;
         end
         S_EXEC:
            state_d = S_ALUWB;
         S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB:
            retire = 1'b1;
         S_ADDIEX:
            state_d = S_ADDIWB;
         default:
            state_d = S_FETCH;
      endcase
      cnt_d = cnt_q + CNT_W'(retire);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
      end
   end

   logic       pc_wr, pc_wr_c, iord, mem_rd, mem_wr, ir_wr;
   logic       m2r, reg_dst, reg_wr, src_a;
   logic [1:0] src_b, alu_op, pc_src;

   always_comb begin
      pc_wr   = 1'b0;
      pc_wr_c = 1'b0;
      iord    = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ir_wr   = 1'b0;
      m2r     = 1'b0;
      reg_dst = 1'b0;
      reg_wr  = 1'b0;
      src_a   = 1'b0;
      src_b   = 2'b00;
      alu_op  = 2'b00;
      pc_src  = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_rd = 1'b1;
            src_b  = 2'b01;
            pc_wr  = bus.mem_ready;
            ir_wr  = bus.mem_ready;
         end
         S_DECODE:
            src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            src_a = 1'b1;
            src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            iord   = 1'b1;
         end
         S_MEMWB: begin
            reg_wr = 1'b1;
            m2r    = 1'b1;
         end
         S_MEMWR: begin
            mem_wr = 1'b1;
            iord   = 1'b1;
         end
         S_EXEC: begin
            src_a  = 1'b1;
            alu_op = 2'b10;
         end
         S_ALUWB: begin
            reg_wr  = 1'b1;
            reg_dst = 1'b1;
         end
         S_BRANCH: begin
            src_a   = 1'b1;
            alu_op  = 2'b01;
            pc_wr_c = 1'b1;
            pc_src  = 2'b01;
         end
         S_JUMP: begin
            pc_wr  = 1'b1;
            pc_src = 2'b10;
         end
         S_ADDIWB:
            reg_wr = 1'b1;
         default: ;
      endcase
      // Reset kills every side-effecting enable in the same cycle.
      if (!reset) begin
         pc_wr   = 1'b0;
         pc_wr_c = 1'b0;
         mem_rd  = 1'b0;
         mem_wr  = 1'b0;
         ir_wr   = 1'b0;
         reg_wr  = 1'b0;
      end
   end

   assign bus.PCWrite     = pc_wr;
   assign bus.PCWriteCond = pc_wr_c;
   assign bus.IorD        = iord;
   assign bus.MemRead     = mem_rd;
   assign bus.MemWrite    = mem_wr;
   assign bus.IRWrite     = ir_wr;
   assign bus.MemtoReg    = m2r;
   assign bus.RegDst      = reg_dst;
   assign bus.RegWrite    = reg_wr;
   assign bus.ALUSrcA     = src_a;
   assign bus.ALUSrcB     = src_b;
   assign bus.ALUOp       = alu_op;
   assign bus.PCSource    = pc_src;
   assign bus.illegal_op  = ill_q;
   assign bus.state       = state_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle expected
// state, control word and counter queued by stimulus, checked by monitor.
module tb_multicycle_control;
   logic clk = 1'b0;
   logic reset = 1'b0;

   multicycle_control_if #(.CNT_W(32)) bus ();

   multicycle_control #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
   //  RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
   localparam logic [16:0] C_FRST = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_FR   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_FS   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_FILL = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_1;
   localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] C_MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] C_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_MRDR = 17'b0_0_1_0_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] C_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_EXE  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] C_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
   localparam logic [16:0] C_IWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_AI  = 6'b001000;
   localparam logic [5:0] OP_BAD = 6'b111111;

   typedef struct {
      int          cyc;
      logic [3:0]  st;
      logic [16:0] ctrl;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   logic [16:0] act;

   task automatic cyc(input logic rst, input logic [5:0] op,
                      input logic mr, input logic [3:0] st,
                      input logic [16:0] ctrl, input logic [31:0] cnt);
      exp_t x;
      @(posedge clk);
      #1;
      reset         = rst;
      bus.opcode    = op;
      bus.mem_ready = mr;
      cyc_n++;
      x.cyc  = cyc_n;
      x.st   = st;
      x.ctrl = ctrl;
      x.cnt  = cnt;
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.illegal_op};
         checks += 3;
         if (bus.state !== e.st) begin
            errors++;
            $display("FAIL state cyc %0d got %0d want %0d",
                     e.cyc, bus.state, e.st);
         end
         if (act !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl cyc %0d got %b want %b",
                     e.cyc, act, e.ctrl);
         end
         if (bus.instr_count !== e.cnt) begin
            errors++;
            $display("FAIL count cyc %0d got %0d want %0d",
                     e.cyc, bus.instr_count, e.cnt);
         end
      end
   end

   initial begin
      bus.opcode    = OP_R;
      bus.mem_ready = 1'b1;
      // reset held two cycles, then release
      cyc(0, OP_R, 1, 4'd0, C_FRST, 0);
      cyc(0, OP_R, 1, 4'd0, C_FRST, 0);
      cyc(1, OP_R, 1, 4'd0, C_FR, 0);
      cyc(1, OP_R, 1, 4'd1, C_DEC, 0);
      cyc(1, OP_BAD, 1, 4'd6, C_EXE, 0);
      cyc(1, OP_BAD, 1, 4'd7, C_AWB, 0);
      // lw with 2 fetch stalls and 3 memrd stalls: 10 cycles
      cyc(1, OP_LW, 0, 4'd0, C_FS, 1);
      cyc(1, OP_LW, 0, 4'd0, C_FS, 1);
      cyc(1, OP_LW, 1, 4'd0, C_FR, 1);
      cyc(1, OP_LW, 1, 4'd1, C_DEC, 1);
      cyc(1, OP_LW, 1, 4'd2, C_MADR, 1);
      cyc(1, OP_LW, 0, 4'd3, C_MRD, 1);
      cyc(1, OP_LW, 0, 4'd3, C_MRD, 1);
      cyc(1, OP_LW, 0, 4'd3, C_MRD, 1);
      cyc(1, OP_LW, 1, 4'd3, C_MRD, 1);
      cyc(1, OP_LW, 1, 4'd4, C_MWB, 1);
      // beq, j, sw
      cyc(1, OP_BEQ, 1, 4'd0, C_FR, 2);
      cyc(1, OP_BEQ, 1, 4'd1, C_DEC, 2);
      cyc(1, OP_BEQ, 1, 4'd8, C_BR, 2);
      cyc(1, OP_J, 1, 4'd0, C_FR, 3);
      cyc(1, OP_J, 1, 4'd1, C_DEC, 3);
      cyc(1, OP_J, 1, 4'd9, C_JMP, 3);
      cyc(1, OP_SW, 1, 4'd0, C_FR, 4);
      cyc(1, OP_SW, 1, 4'd1, C_DEC, 4);
      cyc(1, OP_SW, 1, 4'd2, C_MADR, 4);
      cyc(1, OP_SW, 1, 4'd5, C_MWR, 4);
      // illegal opcode: one-cycle pulse, no retire
      cyc(1, OP_BAD, 1, 4'd0, C_FR, 5);
      cyc(1, OP_BAD, 1, 4'd1, C_DEC, 5);
      cyc(1, OP_AI, 1, 4'd0, C_FILL, 5);
      cyc(1, OP_AI, 1, 4'd1, C_DEC, 5);
      cyc(1, OP_AI, 1, 4'd10, C_MADR, 5);
      cyc(1, OP_AI, 1, 4'd11, C_IWB, 5);
      // reset during a memrd stall
      cyc(1, OP_LW, 1, 4'd0, C_FR, 6);
      cyc(1, OP_LW, 1, 4'd1, C_DEC, 6);
      cyc(1, OP_LW, 1, 4'd2, C_MADR, 6);
      cyc(1, OP_LW, 0, 4'd3, C_MRD, 6);
      cyc(0, OP_LW, 0, 4'd3, C_MRDR, 6);
      cyc(1, OP_R, 1, 4'd0, C_FR, 0);
      cyc(1, OP_R, 1, 4'd1, C_DEC, 0);
      cyc(1, OP_R, 1, 4'd6, C_EXE, 0);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
